// File: rtl/fpga_cfg_pkg.sv
// Shared constants, FSM state encoding and beat-count helper for the fabric config loader.
// Defaults match the fpga fabric top and its wrapper.
package fpga_cfg_pkg;

    localparam int DEF_WORD_W     = 224;
    localparam int DEF_NUM_TILES  = 43;
    localparam int DEF_IN_W       = 32;
    localparam int DEF_SETTLE_CYC = 10;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RUN     = 2'd3
    } cfg_state_e;

    // Number of input beats needed to fill one configuration word.
    function automatic int cfg_beats(input int word_w, input int in_w);
        return (word_w + in_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Purpose: MSB-first shift packer turning IN_W beats into one WORD_W configuration word.
// Latency: word_done/word_next are combinational with the accepting (last) beat.
// Backpressure: none inside; the caller qualifies beat_acc with its own ready.
module cfg_word_packer #(
    parameter int WORD_W = 224,
    parameter int IN_W   = 32,
    parameter int BEATS  = 7
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              beat_acc,
    input  logic [IN_W-1:0]   beat_dat,
    output logic [WORD_W-1:0] word_next,
    output logic              word_done
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    // The oldest beat is pushed out of the top; surplus bits of the first beat fall off.
    assign word_next = WORD_W'({word_q, beat_dat});
    assign word_done = beat_acc && (beat_cnt_q == LAST_BEAT);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat_acc) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (beat_acc) begin
                word_q <= word_next;
            end
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Purpose: stream bitstream beats into per-tile config words, write tiles in order, then enable the fabric.
// Latency: BEATS accept cycles + 1 write cycle per tile; ff_en SETTLE_CYC+1 and rdy SETTLE_CYC+2 cycles after the last write.
// Backpressure: cfg_ready low during reset, each WRITE cycle, SETTLE and RUN; extra beats stall forever.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int NUM_TILES  = DEF_NUM_TILES,
    parameter int IN_W       = DEF_IN_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [IN_W-1:0]      cfg_data,
    output logic                 cfg_ready,
    output logic [WORD_W-1:0]    configs_in,
    output logic [NUM_TILES-1:0] configs_en,
    output logic                 ff_en,
    output logic                 rdy
);

    localparam int BEATS  = cfg_beats(WORD_W, IN_W);
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int GAP_W  = $clog2(SETTLE_CYC + 1);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(SETTLE_CYC - 1);

    cfg_state_e           state_q, state_d;
    logic                 live_q;
    logic [TILE_W-1:0]    tile_cnt_q, tile_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0]    configs_in_q;
    logic [NUM_TILES-1:0] configs_en_q, configs_en_d;
    logic                 ff_en_q, rdy_q;

    logic                 beat_acc;
    logic                 word_done;
    logic [WORD_W-1:0]    word_next;

    // live_q keeps cfg_ready low until the first edge after reset release.
    assign cfg_ready  = live_q && (state_q == ST_COLLECT);
    assign beat_acc   = cfg_valid && cfg_ready;

    assign configs_in = configs_in_q;
    assign configs_en = configs_en_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;

    cfg_word_packer #(
        .WORD_W (WORD_W),
        .IN_W   (IN_W),
        .BEATS  (BEATS)
    ) u_packer (
        .clock     (clock),
        .rst       (rst),
        .beat_acc  (beat_acc),
        .beat_dat  (cfg_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    always_comb begin
        state_d      = state_q;
        tile_cnt_d   = tile_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        configs_en_d = '0;
        case (state_q)
            ST_COLLECT: begin
                if (word_done) begin
                    state_d      = ST_WRITE;
                    configs_en_d = NUM_TILES'(1) << tile_cnt_q;
                end
            end
            ST_WRITE: begin
                if (tile_cnt_q < LAST_TILE) begin
                    tile_cnt_d = tile_cnt_q + 1'b1;
                    state_d    = ST_COLLECT;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_COLLECT;
            live_q       <= 1'b0;
            tile_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            configs_in_q <= '0;
            configs_en_q <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            tile_cnt_q   <= tile_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            configs_en_q <= configs_en_d;
            if (word_done) begin
                configs_in_q <= word_next;
            end
            // rdy trails ff_en by one cycle so the fabric sees its flops enabled first.
            ff_en_q      <= (state_d == ST_RUN);
            rdy_q        <= ff_en_q;
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: reset, single word, full loads with and without gaps,
// post-completion stall and mid-load reset.
module tb_fpga_config_loader;

    localparam int WORD_W    = 224;
    localparam int NUM_TILES = 43;
    localparam int IN_W      = 32;

    logic                 clock;
    logic                 rst;
    logic                 cfg_valid;
    logic [IN_W-1:0]      cfg_data;
    logic                 cfg_ready;
    logic [WORD_W-1:0]    configs_in;
    logic [NUM_TILES-1:0] configs_en;
    logic                 ff_en;
    logic                 rdy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ff_cyc  = -1;
    int rdy_cyc = -1;

    logic [NUM_TILES-1:0] st_en[$];
    logic [WORD_W-1:0]    st_dat[$];
    int                   st_cyc[$];

    fpga_config_loader dut (
        .clock      (clock),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor: records every tile write and checks one-hot and ready-low on each.
    always @(negedge clock) begin
        if (!rst) begin
            ff_cyc  = -1;
            rdy_cyc = -1;
        end else begin
            if (configs_en != '0) begin
                st_en.push_back(configs_en);
                st_dat.push_back(configs_in);
                st_cyc.push_back(cyc);
                checks++;
                if ($countones(configs_en) != 1) begin
                    errors++;
                    $display("FAIL strobe_onehot: configs_en=%h has %0d bits set, required 1", configs_en, $countones(configs_en));
                end
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_write: cfg_ready=%b during strobe, required 0", cfg_ready);
                end
            end
            if (ff_en === 1'b1 && ff_cyc < 0) ff_cyc = cyc;
            if (rdy === 1'b1 && rdy_cyc < 0) rdy_cyc = cyc;
        end
    end

    function automatic logic [WORD_W-1:0] exp_word(input int k);
        logic [31:0] b;
        b = 32'(k);
        return {b, b, b, b, b, b, b};
    endfunction

    task automatic clear_log();
        st_en.delete();
        st_dat.delete();
        st_cyc.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b1;
        clear_log();
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic send_beat(input logic [IN_W-1:0] d, input int gap_pct);
        logic acc;
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            cfg_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clock);
            acc = cfg_ready;
            @(posedge clock);
            #1;
        end
        if (!acc) begin
            errors++;
            $display("FAIL beat_accept: beat %h not accepted within 50 cycles, required acceptance", d);
        end
    endtask

    task automatic send_load(input int base, input int gap_pct);
        for (int k = 0; k < NUM_TILES; k++) begin
            for (int b = 0; b < 7; b++) send_beat(32'(base + k), gap_pct);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_rdy();
        for (int t = 0; t < 600 && rdy !== 1'b1; t++) @(negedge clock);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_timeout: rdy=%b after 600 cycles, required 1", rdy);
        end
        @(negedge clock);
    endtask

    task automatic check_load(input int base, input string tag);
        logic [NUM_TILES-1:0] one;
        int n;
        one = 1;
        wait_rdy();
        checks++;
        if (st_en.size() != NUM_TILES) begin
            errors++;
            $display("FAIL %s_strobe_count: %0d strobes, required %0d", tag, st_en.size(), NUM_TILES);
        end
        n = (st_en.size() < NUM_TILES) ? st_en.size() : NUM_TILES;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (st_en[k] !== (one << k) || st_dat[k] !== exp_word(base + k)) begin
                errors++;
                $display("FAIL %s_word%0d: en=%h dat=%h, required en=%h dat=%h", tag, k, st_en[k], st_dat[k], one << k, exp_word(base + k));
            end
        end
        if (n > 0) begin
            checks++;
            if (ff_cyc - st_cyc[n-1] != 11) begin
                errors++;
                $display("FAIL %s_ff_en_delay: %0d cycles after last strobe, required 11", tag, ff_cyc - st_cyc[n-1]);
            end
            checks++;
            if (rdy_cyc - st_cyc[n-1] != 12) begin
                errors++;
                $display("FAIL %s_rdy_delay: %0d cycles after last strobe, required 12", tag, rdy_cyc - st_cyc[n-1]);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        cfg_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = (i % 2 == 0);
            @(negedge clock);
            checks++;
            if (cfg_ready !== 1'b0 || configs_en !== '0 || configs_in !== '0 || ff_en !== 1'b0 || rdy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b en=%h in=%h ff_en=%b rdy=%b, required all 0", cfg_ready, configs_en, configs_in, ff_en, rdy);
            end
            @(posedge clock);
            #1;
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_clk: cfg_ready=%b, required 0", cfg_ready);
        end
        @(negedge clock);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: cfg_ready=%b, required 1", cfg_ready);
        end
    endtask

    task automatic test_one_word();
        logic [WORD_W-1:0] w;
        w = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        do_reset();
        for (int b = 1; b <= 7; b++) send_beat(32'(b), 0);
        cfg_data = 32'h0000_0008;
        @(negedge clock);
        checks++;
        if (configs_en !== 43'h1 || configs_in !== w || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL one_word_write: en=%h in=%h ready=%b, required en=1 in=%h ready=0", configs_en, configs_in, cfg_ready, w);
        end
        cfg_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (configs_en !== '0 || configs_in !== w || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_word_after: en=%h in=%h ready=%b, required en=0 in held ready=1", configs_en, configs_in, cfg_ready);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (st_en.size() != 1) begin
            errors++;
            $display("FAIL one_word_strobes: %0d strobes, required 1", st_en.size());
        end
    endtask

    task automatic test_full_load();
        do_reset();
        send_load(0, 0);
        check_load(0, "b2b");
    endtask

    task automatic test_gaps();
        do_reset();
        send_load(0, 30);
        check_load(0, "gaps");
    endtask

    task automatic test_post_rdy_stall();
        int n0;
        n0 = st_en.size();
        cfg_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cfg_data = $urandom;
            @(negedge clock);
            checks++;
            if (cfg_ready !== 1'b0 || configs_en !== '0 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL post_rdy_cyc%0d: ready=%b en=%h rdy=%b, required ready=0 en=0 rdy=1", i, cfg_ready, configs_en, rdy);
            end
            @(posedge clock);
            #1;
        end
        cfg_valid = 1'b0;
        checks++;
        if (st_en.size() != n0) begin
            errors++;
            $display("FAIL post_rdy_strobes: %0d new strobes, required 0", st_en.size() - n0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 7; b++) send_beat(32'(k), 0);
        end
        for (int b = 0; b < 3; b++) send_beat(32'h55, 0);
        cfg_valid = 1'b0;
        rst = 1'b0;
        @(negedge clock);
        checks++;
        if (configs_in !== '0 || configs_en !== '0 || cfg_ready !== 1'b0 || ff_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: in=%h en=%h ready=%b ff_en=%b, required all 0", configs_in, configs_en, cfg_ready, ff_en);
        end
        @(posedge clock);
        #1;
        rst = 1'b1;
        clear_log();
        send_load(200, 0);
        check_load(200, "restart");
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        test_reset();
        test_one_word();
        test_full_load();
        test_gaps();
        test_post_rdy_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
